// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the data-memory load/store controller.
//   size_e  : request size encodings (byte/half/word, 3 is illegal)
//   state_e : controller state machine states
//   DEFAULT_MEM_BYTES : default data memory size in bytes
package mem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_ILL  = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    IDLE,
    RD_WAIT,
    WR,
    RESP
  } state_e;

  localparam int unsigned DEFAULT_MEM_BYTES = 1024;

endpackage

// File: rtl/mem_access_unit_if.sv
// Request/response handshake plus data-memory bus of mem_access_unit.
//   master : CPU datapath side (drives requests, consumes responses)
//   slave  : the load/store controller itself
//   mem    : the data memory (consumes strobes, returns read word)
interface mem_access_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_w;
  logic        mem_r;
  logic [31:0] mem_rdata;

  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    output resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    input  resp_ready, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_addr, mem_wdata, mem_w, mem_r
  );

  modport mem (
    input  mem_addr, mem_wdata, mem_w, mem_r,
    output mem_rdata
  );
endinterface

// File: rtl/mem_access_unit_lane_align.sv
// Combinational byte-lane handling for a big-endian 32-bit memory.
//   size       : access size of the registered request
//   sign_ext   : sign-extend byte/half loads
//   rdata      : word read from memory at the request address
//   wdata      : right-justified store data
//   load_data  : extracted, zero/sign-extended load result
//   store_word : full word to write (store data merged over rdata)
// The addressed byte is always the most significant byte of the word read
// at that address, so no address-dependent lane selection is needed.
module mem_lane_align
  import mem_pkg::*;
(
  input  size_e       size,
  input  logic        sign_ext,
  input  logic [31:0] rdata,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  always_comb begin
    load_data  = rdata;
    store_word = wdata;
    case (size)
      SZ_BYTE: begin
        load_data  = {{24{sign_ext & rdata[31]}}, rdata[31:24]};
        store_word = {wdata[7:0], rdata[23:0]};
      end
      SZ_HALF: begin
        load_data  = {{16{sign_ext & rdata[31]}}, rdata[31:16]};
        store_word = {wdata[15:0], rdata[15:0]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Initiator-side load/store controller for the big-endian data memory.
// Waits READ_LAT cycles on every read and performs read-modify-write for
// byte and half stores; word stores are written directly.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : request/response handshake and memory bus (slave modport)
// Parameters: READ_LAT (1..15) read hold cycles, MEM_BYTES memory size.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int unsigned READ_LAT  = 4,
  parameter int unsigned MEM_BYTES = DEFAULT_MEM_BYTES
) (
  input  logic       clk,
  input  logic       rst_n,
  mem_access_unit_if.slave bus
);

  localparam logic [3:0] LAT_INIT = 4'(READ_LAT - 1);

  state_e      state, state_n;
  logic [3:0]  cnt;
  logic        r_write;
  logic        r_signed;
  size_e       r_size;
  logic [31:0] r_wdata;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;
  logic [31:0] resp_rdata_q;
  logic        resp_err_q;

  size_e       req_sz;
  logic [32:0] req_end;
  logic        req_err;
  logic        req_word_st;
  logic [31:0] load_word;
  logic [31:0] store_word;

  assign req_sz      = size_e'(bus.req_size);
  assign req_word_st = bus.req_write && (req_sz == SZ_WORD);

  // Last byte touched is addr+3; 33-bit sum so a wrap past 2^32 still errors.
  always_comb begin
    req_end = {1'b0, bus.req_addr} + 33'd3;
    req_err = 1'b0;
    case (req_sz)
      SZ_HALF: req_err = bus.req_addr[0];
      SZ_WORD: req_err = |bus.req_addr[1:0];
      SZ_ILL:  req_err = 1'b1;
      default: ;
    endcase
    if (req_end >= 33'(MEM_BYTES)) req_err = 1'b1;
  end

  mem_lane_align u_lane (
    .size       (r_size),
    .sign_ext   (r_signed),
    .rdata      (bus.mem_rdata),
    .wdata      (r_wdata),
    .load_data  (load_word),
    .store_word (store_word)
  );

  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (bus.req_valid) begin
          if (req_err)          state_n = RESP;
          else if (req_word_st) state_n = WR;
          else                  state_n = RD_WAIT;
        end
      end
      RD_WAIT: if (cnt == '0) state_n = r_write ? WR : RESP;
      WR:      state_n = RESP;
      RESP:    if (bus.resp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign bus.req_ready  = (state == IDLE);
  assign bus.resp_valid = (state == RESP);
  assign bus.mem_r      = (state == RD_WAIT);
  assign bus.mem_w      = (state == WR);
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      r_write      <= 1'b0;
      r_signed     <= 1'b0;
      r_size       <= SZ_BYTE;
      r_wdata      <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            r_write      <= bus.req_write;
            r_signed     <= bus.req_signed;
            r_size       <= req_sz;
            r_wdata      <= bus.req_wdata;
            cnt          <= LAT_INIT;
            resp_err_q   <= req_err;
            resp_rdata_q <= '0;
            // Memory address/data only move for requests that will strobe.
            if (!req_err) mem_addr_q <= bus.req_addr;
            if (!req_err && req_word_st) mem_wdata_q <= bus.req_wdata;
          end
        end
        RD_WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - 4'd1;
          end else if (r_write) begin
            mem_wdata_q <= store_word;
          end else begin
            resp_rdata_q <= load_word;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed scenarios followed by
// randomized requests, checked against a byte-array reference model.
module tb_mem_access_unit;

  localparam int unsigned READ_LAT  = 4;
  localparam int unsigned MEM_BYTES = 1024;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  mem_access_unit_if bus ();

  mem_access_unit #(.READ_LAT(READ_LAT), .MEM_BYTES(MEM_BYTES)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Behavioural memory: read data is junk until the address has been held
  // for READ_LAT cycles, so early or late sampling is visible.
  logic [7:0]  mem     [MEM_BYTES];
  logic [7:0]  ref_mem [MEM_BYTES];
  int unsigned hold = 0;
  int          wcount = 0;
  int          rcount = 0;
  int          overlap = 0;
  logic [31:0] last_wd = '0;
  logic [31:0] last_wa = '0;
  logic [31:0] rd_word;

  always_comb begin
    rd_word = 32'h5A5A_A5A5;
    if (bus.mem_r && hold >= READ_LAT - 1 && bus.mem_addr <= 32'(MEM_BYTES - 4))
      rd_word = {mem[int'(bus.mem_addr)], mem[int'(bus.mem_addr) + 1],
                 mem[int'(bus.mem_addr) + 2], mem[int'(bus.mem_addr) + 3]};
  end
  assign bus.mem_rdata = rd_word;

  always @(posedge clk) begin
    if (bus.mem_w && bus.mem_r) overlap++;
    if (bus.mem_r) rcount++;
    hold <= bus.mem_r ? hold + 1 : 0;
    if (bus.mem_w) begin
      wcount++;
      last_wd = bus.mem_wdata;
      last_wa = bus.mem_addr;
      if (bus.mem_addr <= 32'(MEM_BYTES - 4))
        for (int i = 0; i < 4; i++)
          mem[int'(bus.mem_addr) + i] <= bus.mem_wdata[8*(3-i) +: 8];
    end
  end

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input int idx);
    return {ref_mem[idx], ref_mem[idx + 1], ref_mem[idx + 2], ref_mem[idx + 3]};
  endfunction

  // Issue one request starting at a negedge; returns at the negedge after
  // the response handshake, so a following call is back-to-back.
  task automatic run_req(input logic w, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd,
                         input int hold_cyc, input string tag);
    logic [32:0] endp;
    logic        e;
    logic [31:0] v, exp_rd, exp_wd, snap;
    int          idx, exp_lat, exp_reads, lat, w0, r0;
    endp   = {1'b0, a} + 33'd3;
    e      = (sz == 2'd3) || (sz == 2'd1 && a[0]) ||
             (sz == 2'd2 && a[1:0] != 2'b00) || (endp >= 33'(MEM_BYTES));
    idx    = e ? 0 : int'(a);
    exp_rd = '0;
    exp_wd = '0;
    if (!e && !w) begin
      case (sz)
        2'd0: begin
          v = {24'b0, ref_mem[idx]};
          if (sg && v >= 32'd128) v = v - 32'd256;
        end
        2'd1: begin
          v = {16'b0, ref_mem[idx], ref_mem[idx + 1]};
          if (sg && v >= 32'h8000) v = v - 32'h10000;
        end
        default: v = ref_word(idx);
      endcase
      exp_rd = v;
    end
    if (!e && w) begin
      case (sz)
        2'd0: ref_mem[idx] = wd[7:0];
        2'd1: begin ref_mem[idx] = wd[15:8]; ref_mem[idx + 1] = wd[7:0]; end
        default: for (int i = 0; i < 4; i++) ref_mem[idx + i] = wd[8*(3-i) +: 8];
      endcase
      exp_wd = ref_word(idx);
    end
    exp_lat   = e ? 1 : (!w ? READ_LAT + 1 : (sz == 2'd2 ? 2 : READ_LAT + 2));
    exp_reads = (e || (w && sz == 2'd2)) ? 0 : READ_LAT;

    w0 = wcount;
    r0 = rcount;
    chk({tag, ":req_ready"}, 32'(bus.req_ready), 32'd1);
    bus.req_valid  = 1'b1;
    bus.req_write  = w;
    bus.req_size   = sz;
    bus.req_signed = sg;
    bus.req_addr   = a;
    bus.req_wdata  = wd;
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_wdata = $urandom;
    lat = 1;
    while (!bus.resp_valid && lat < 64) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, ":latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, ":resp_err"}, 32'(bus.resp_err), 32'(e));
    chk({tag, ":resp_rdata"}, bus.resp_rdata, exp_rd);
    snap = bus.resp_rdata;
    for (int i = 0; i < hold_cyc; i++) begin
      @(negedge clk);
      chk({tag, ":hold_valid"}, 32'(bus.resp_valid), 32'd1);
      chk({tag, ":hold_rdata"}, bus.resp_rdata, snap);
      chk({tag, ":hold_ready"}, 32'(bus.req_ready), 32'd0);
    end
    bus.resp_ready = 1'b1;
    @(negedge clk);
    bus.resp_ready = 1'b0;
    chk({tag, ":idle_after"}, 32'(bus.resp_valid), 32'd0);
    chk({tag, ":writes"}, 32'(wcount - w0), 32'(w && !e));
    chk({tag, ":read_cycles"}, 32'(rcount - r0), 32'(exp_reads));
    if (w && !e) begin
      chk({tag, ":mem_wdata"}, last_wd, exp_wd);
      chk({tag, ":mem_addr"}, last_wa, a);
    end
  endtask

  initial begin
    int w0;
    logic [31:0] a;
    int pick;
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_size   = 2'd0;
    bus.req_signed = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.resp_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst:req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst:resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst:resp_err", 32'(bus.resp_err), 32'd0);
    chk("rst:resp_rdata", bus.resp_rdata, 32'd0);
    chk("rst:mem_strobes", {30'd0, bus.mem_w, bus.mem_r}, 32'd0);
    chk("rst:mem_addr", bus.mem_addr, 32'd0);
    chk("rst:mem_wdata", bus.mem_wdata, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_req(1'b1, 2'd2, 1'b0, 32'd8, 32'hDEADBEEF, 0, "word_st8");
    run_req(1'b0, 2'd2, 1'b0, 32'd8, 32'h0, 0, "word_ld8");
    chk("word_ld8:value", bus.resp_rdata, 32'hDEADBEEF);
    run_req(1'b1, 2'd2, 1'b0, 32'd8, 32'h11223344, 0, "word_st8b");
    run_req(1'b1, 2'd0, 1'b0, 32'd8, 32'h000000AA, 0, "byte_st8");
    chk("byte_st8:merge", last_wd, 32'hAA223344);
    run_req(1'b0, 2'd2, 1'b0, 32'd8, 32'h0, 0, "word_ld8b");
    run_req(1'b1, 2'd2, 1'b0, 32'd12, 32'h80F01234, 0, "word_st12");
    run_req(1'b0, 2'd0, 1'b1, 32'd12, 32'h0, 0, "sbyte_ld12");
    run_req(1'b0, 2'd0, 1'b0, 32'd12, 32'h0, 0, "ubyte_ld12");
    run_req(1'b0, 2'd1, 1'b1, 32'd12, 32'h0, 0, "shalf_ld12");
    run_req(1'b0, 2'd1, 1'b0, 32'd5, 32'h0, 0, "err_half5");
    run_req(1'b0, 2'd2, 1'b0, 32'd1021, 32'h0, 0, "err_word1021");
    run_req(1'b1, 2'd3, 1'b0, 32'd0, 32'h12345678, 0, "err_size3");
    run_req(1'b0, 2'd2, 1'b0, 32'd8, 32'h0, 5, "hold_ld8");

    // Reset in the middle of a byte store's read phase.
    run_req(1'b1, 2'd2, 1'b0, 32'd16, 32'h0BADF00D, 0, "word_st16");
    w0 = wcount;
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_size  = 2'd0;
    bus.req_addr  = 32'd16;
    bus.req_wdata = 32'h00000077;
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk("abort:in_read", 32'(bus.mem_r), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort:req_ready", 32'(bus.req_ready), 32'd1);
    chk("abort:resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("abort:resp_err", 32'(bus.resp_err), 32'd0);
    chk("abort:resp_rdata", bus.resp_rdata, 32'd0);
    chk("abort:mem_strobes", {30'd0, bus.mem_w, bus.mem_r}, 32'd0);
    chk("abort:mem_addr", bus.mem_addr, 32'd0);
    chk("abort:mem_wdata", bus.mem_wdata, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (READ_LAT + 4) @(negedge clk);
    chk("abort:no_write", 32'(wcount - w0), 32'd0);
    chk("abort:mem16", {mem[16], mem[17], mem[18], mem[19]}, 32'h0BADF00D);
    run_req(1'b0, 2'd2, 1'b0, 32'd16, 32'h0, 0, "abort:ld16");

    // Randomized phase: initialise both ends of memory, then mix requests.
    for (int i = 0; i < 34; i++) run_req(1'b1, 2'd2, 1'b0, 32'(i * 4), $urandom, 0, "pre_lo");
    run_req(1'b1, 2'd2, 1'b0, 32'd1016, $urandom, 0, "pre_hi0");
    run_req(1'b1, 2'd2, 1'b0, 32'd1020, $urandom, 0, "pre_hi1");
    for (int i = 0; i < 150; i++) begin
      pick = int'($urandom_range(0, 9));
      if (pick < 7)      a = 32'($urandom_range(0, 131));
      else if (pick < 9) a = 32'(1016 + $urandom_range(0, 11));
      else               a = $urandom;
      pick = int'($urandom_range(0, 9));
      run_req(1'($urandom_range(0, 1)),
              pick < 3 ? 2'd0 : (pick < 6 ? 2'd1 : (pick < 9 ? 2'd2 : 2'd3)),
              1'($urandom_range(0, 1)), a, $urandom,
              int'($urandom_range(0, 2)), "rnd");
    end

    chk("rw_overlap", 32'(overlap), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
